sprite_rom_arbiter: RTL and testbench
=====================================

// Module: sprite_rom_arbiter
// PURPOSE
//  Shares one read port of a sprite/tile index BRAM (xilinx_single_port_ram_read_first, HIGH_PERFORMANCE) among
//  NUM_REQ requesters: track tiles, player kart, opponent kart and item/HUD overlay. Round-robin, one grant per cycle.
//  Sits between the track-view pixel pipeline stages and the ROM and returns each read tagged by requester, so
//  per-sprite ROM copies collapse into one. Flags requesters that wait longer than a programmable bound.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8); index 0 = track tiles
//  ADDR_W       10  ROM address width (32x32 sprite = 1024 words)
//  DATA_W       8   ROM word width (palette index)
//  RAM_LATENCY  2   ROM read latency in cycles (2 = HIGH_PERFORMANCE output register)
//  MAX_WAIT     15  cycles a pending request may wait before its starve flag sets
// PORTS
//  clk_in         in   1                pixel clock
//  rst_in         in   1                asynchronous, active-low reset
//  req_valid_in   in   NUM_REQ          per-requester read request
//  req_addr_in    in   NUM_REQ*ADDR_W   per-requester address, packed [NUM_REQ-1:0][ADDR_W-1:0]
//  req_ready_out  out  NUM_REQ          one-hot grant: request accepted this cycle
//  ram_en_out     out  1                ROM enable (to ena)
//  ram_addr_out   out  ADDR_W           ROM address (to addra)
//  ram_data_in    in   DATA_W           ROM read data (from douta)
//  rsp_valid_out  out  NUM_REQ          one-hot: rsp_data_out belongs to this requester
//  rsp_data_out   out  DATA_W           returned ROM word (pass-through of ram_data_in)
//  starve_out     out  NUM_REQ          sticky per-requester starvation flag
//  starve_clr_in  in   1                clears all starve_out bits (synchronous)
// BEHAVIOUR
//  - Reset (rst_in=0, async): rr pointer=0, tag pipe cleared, wait counters=0. req_ready_out=0, ram_en_out=0,
//    ram_addr_out=0, rsp_valid_out=0, starve_out=0. In-flight reads are dropped, with no response after reset.
//  - Grant (combinational from req_valid_in and the pointer): first valid index at or after ptr, modulo NUM_REQ.
//    req_ready_out = that one-hot; all zeros if no request. Handshake occurs on valid&ready. Requester holds
//    valid and addr stable until ready. Dropping valid before ready is legal and has no side effects.
//  - ram_en_out = |req_ready_out. ram_addr_out = granted address. Both are combinational in the grant cycle.
//  - Pointer: after a grant to i, ptr <= (i+1) mod NUM_REQ. Unchanged when idle. At i=NUM_REQ-1 it wraps to 0.
//  - Tag pipe: RAM_LATENCY-deep shift register of one-hot grants. rsp_valid_out = stage RAM_LATENCY-1.
//    A response appears exactly RAM_LATENCY cycles after its handshake. Back-to-back grants give back-to-back
//    responses. No backpressure on responses.
//  - Wait counter per requester: counts cycles with valid=1 and ready=0, saturating at MAX_WAIT.
//    Resets to 0 on handshake or when valid=0. Reaching MAX_WAIT sets starve_out[i].
//  - starve_out[i] stays set until starve_clr_in. If a clear and a set happen in the same cycle, the set wins.
//  - All requesters continuously valid: grants rotate 0,1,..,NUM_REQ-1,0, and each waits NUM_REQ-1 cycles.
// CONFIGURATION
//  - SPRITE_ARB_PRIO0_EN defined: requester 0 (track tiles, the display-critical path) has strict priority.
//    It is granted whenever valid, without moving the pointer. The others share round-robin grants among
//    themselves when 0 is idle.
//  - Not defined: plain round-robin over all NUM_REQ, as described above.
// STRUCTURE
//  - Package sprite_arb_pkg: NUM_REQ_MAX=8, typedef req_onehot_t, typedef rom_addr_t, and function rr_pick
//    (pointer plus request vector to one-hot).
//  - Sub-module rr_arbiter_core: request vector and pointer register to one-hot grant, with pointer update.
//    It is reused later by palette-ROM sharing.
//  - This module adds the address mux, tag pipe, wait counters and starve flags.
// TESTING
//  1. Reset while read in flight: grant req1 addr 0x05, assert rst_in low the next cycle -> all outputs 0,
//     no rsp_valid_out after release.
//  2. Single requester: req2 valid, addr 0x3A1, ROM word 0x7C -> ready[2] same cycle, ram_addr_out=0x3A1,
//     rsp_valid_out=4'b0100 with data 0x7C two cycles later.
//  3. All four valid for 8 cycles, addrs 0x000/0x100/0x200/0x300 -> grant order 0,1,2,3,0,1,2,3.
//     Responses are in the same order with latency 2, and no starve flag is set.
//  4. Pointer wrap: ptr at 3, only req3 and req0 valid -> grants 3 then 0, and ptr returns to 1.
//  5. Starvation with SPRITE_ARB_PRIO0_EN: req0 valid for 20 cycles, req1 valid -> req1 never granted,
//     starve_out[1]=1 after 15 waiting cycles. starve_clr_in clears it only once the set condition is gone.
//  6. Without the macro, same stimulus -> grants alternate 0,1, and starve_out stays 0.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// Shared types and the round-robin pick function for sprite/palette ROM arbitration.
// Used by rr_arbiter_core and sprite_rom_arbiter.
package sprite_arb_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int PTR_W       = $clog2(NUM_REQ_MAX);
  localparam int ROM_ADDR_W  = 10;

  typedef logic [NUM_REQ_MAX-1:0] req_onehot_t;
  typedef logic [ROM_ADDR_W-1:0]  rom_addr_t;

  // First set bit of req at or after ptr, wrapping modulo n (only the low n bits take part).
  function automatic req_onehot_t rr_pick(input logic [PTR_W-1:0] ptr,
                                          input req_onehot_t      req,
                                          input int               n);
    req_onehot_t grant;
    logic        found;
    int          idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k < n) && !found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin arbiter: request vector plus pointer register to a one-hot grant.
// The pointer moves one past the winner after every grant and holds while idle or disabled.
module rr_arbiter_core
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_next;
  logic [PTR_W-1:0] grant_idx;
  req_onehot_t      req_ext;
  req_onehot_t      pick;
  int               nxt;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick                   = rr_pick(PTR_W'(ptr), req_ext, NUM_REQ);
    grant                  = '0;
    grant_idx              = '0;
    for (int i = 0; i < NUM_REQ_MAX; i++) begin
      if (pick[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = en & pick[i];
    end
    // Pointer lands one past the winner, wrapping at NUM_REQ.
    nxt = int'(grant_idx) + 1;
    if (nxt >= NUM_REQ) begin
      nxt = 0;
    end
    ptr_next = PW'(nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite-index ROM read port among NUM_REQ pixel-pipeline requesters, tags responses, flags starvation.
// Build option: define SPRITE_ARB_PRIO0_EN to give requester 0 (track tiles) strict priority.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int RAM_LATENCY = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic                           ram_en_out,
  output logic [ADDR_W-1:0]              ram_addr_out,
  input  logic [DATA_W-1:0]              ram_data_in,
  output logic [NUM_REQ-1:0]             rsp_valid_out,
  output logic [DATA_W-1:0]              rsp_data_out,
  output logic [NUM_REQ-1:0]             starve_out,
  input  logic                           starve_clr_in
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic                                core_en;
  logic [NUM_REQ-1:0]                  core_req;
  logic [NUM_REQ-1:0]                  core_grant;
  logic [NUM_REQ-1:0]                  grant;
  logic [ADDR_W-1:0]                   ram_addr;
  logic [RAM_LATENCY-1:0][NUM_REQ-1:0] tag_pipe;
  logic [NUM_REQ-1:0][WAIT_W-1:0]      wait_cnt;
  logic [NUM_REQ-1:0][WAIT_W-1:0]      wait_next;
  logic [NUM_REQ-1:0]                  starve_set;
  logic [NUM_REQ-1:0]                  starve;

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ)
  ) u_core (
    .clk   (clk_in),
    .rst_n (rst_in),
    .en    (core_en),
    .req   (core_req),
    .grant (core_grant)
  );

  // Grants are forced to zero while reset is held so no ROM read or handshake leaks out.
`ifdef SPRITE_ARB_PRIO0_EN
  always_comb begin
    core_req    = req_valid_in;
    core_req[0] = 1'b0;
    core_en     = rst_in & ~req_valid_in[0];
    grant       = core_grant;
    if (rst_in && req_valid_in[0]) begin
      grant    = '0;
      grant[0] = 1'b1;
    end
  end
`else
  always_comb begin
    core_req = req_valid_in;
    core_en  = rst_in;
    grant    = core_grant;
  end
`endif

  always_comb begin
    ram_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ram_addr = ram_addr | (req_addr_in[i] & {ADDR_W{grant[i]}});
    end
  end

  // Tag pipe mirrors the ROM latency so each returning word carries its requester.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= grant;
      for (int s = 1; s < RAM_LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  always_comb begin
    wait_next  = '0;
    starve_set = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid_in[i] && !grant[i]) begin
        wait_next[i]  = (wait_cnt[i] == WAIT_W'(MAX_WAIT)) ? wait_cnt[i]
                                                           : wait_cnt[i] + WAIT_W'(1);
        starve_set[i] = (wait_next[i] == WAIT_W'(MAX_WAIT));
      end
    end
  end

  // A set in the same cycle as a clear wins, so a requester still starving keeps its flag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wait_cnt <= '0;
      starve   <= '0;
    end else begin
      wait_cnt <= wait_next;
      starve   <= (starve & ~{NUM_REQ{starve_clr_in}}) | starve_set;
    end
  end

  assign req_ready_out = grant;
  assign ram_en_out    = |grant;
  assign ram_addr_out  = ram_addr;
  assign rsp_valid_out = tag_pipe[RAM_LATENCY-1];
  assign rsp_data_out  = ram_data_in;
  assign starve_out    = starve;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a 2-cycle ROM model.
// Picks the priority or round-robin expectations from SPRITE_ARB_PRIO0_EN.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;

  logic                           clk_in = 1'b0;
  logic                           rst_in = 1'b0;
  logic [NUM_REQ-1:0]             req_valid_in = '0;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in = '0;
  logic [NUM_REQ-1:0]             req_ready_out;
  logic                           ram_en_out;
  logic [ADDR_W-1:0]              ram_addr_out;
  logic [DATA_W-1:0]              ram_data_in = '0;
  logic [DATA_W-1:0]              rom_q1 = '0;
  logic [NUM_REQ-1:0]             rsp_valid_out;
  logic [DATA_W-1:0]              rsp_data_out;
  logic [NUM_REQ-1:0]             starve_out;
  logic                           starve_clr_in = 1'b0;

  int vector_count = 0;
  int miss_count   = 0;

  sprite_rom_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .RAM_LATENCY (2),
    .MAX_WAIT    (15)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_addr_in   (req_addr_in),
    .req_ready_out (req_ready_out),
    .ram_en_out    (ram_en_out),
    .ram_addr_out  (ram_addr_out),
    .ram_data_in   (ram_data_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out),
    .starve_out    (starve_out),
    .starve_clr_in (starve_clr_in)
  );

  always #5 clk_in = ~clk_in;

  // ROM contents: 0x3A1 -> 0x7C, 0x000 -> 0xDE, 0x100 -> 0xDF, 0x200 -> 0xDC, 0x300 -> 0xDD.
  function automatic logic [7:0] rom_word(input logic [9:0] a);
    return a[7:0] ^ 8'hDD ^ {6'b0, ~a[9:8]};
  endfunction

  always @(posedge clk_in) begin
    if (ram_en_out) rom_q1 <= rom_word(ram_addr_out);
    ram_data_in <= rom_q1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [9:0] a0, input logic [9:0] a1,
                               input logic [9:0] a2, input logic [9:0] a3, input logic clr);
    req_valid_in  = valid;
    req_addr_in   = {a3, a2, a1, a0};
    starve_clr_in = clr;
  endtask

  task automatic stepCycle;
    @(posedge clk_in);
    #1;
  endtask

  logic [3:0] grant_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [7:0] data_seq  [4] = '{8'hDE, 8'hDF, 8'hDC, 8'hDD};
  logic [3:0] exp_ready;
  logic [3:0] exp_starve;

  initial begin
    // Power-on reset
    applyStimulus(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 1'b0);
    @(negedge clk_in);
    checkOutput("rst_ready", 32'(req_ready_out), 'h0);
    checkOutput("rst_en", 32'(ram_en_out), 'h0);
    checkOutput("rst_addr", 32'(ram_addr_out), 'h0);
    checkOutput("rst_rsp", 32'(rsp_valid_out), 'h0);
    checkOutput("rst_starve", 32'(starve_out), 'h0);
    stepCycle();
    rst_in = 1'b1;

    // Reset while a read is in flight
    applyStimulus(4'b0010, 10'h0, 10'h005, 10'h0, 10'h0, 1'b0);
    @(negedge clk_in);
    checkOutput("t1_ready", 32'(req_ready_out), 'h2);
    checkOutput("t1_addr", 32'(ram_addr_out), 'h005);
    stepCycle();
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("t1_rst_ready", 32'(req_ready_out), 'h0);
    checkOutput("t1_rst_en", 32'(ram_en_out), 'h0);
    checkOutput("t1_rst_addr", 32'(ram_addr_out), 'h0);
    checkOutput("t1_rst_rsp", 32'(rsp_valid_out), 'h0);
    stepCycle();
    rst_in = 1'b1;
    applyStimulus(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      checkOutput("t1_no_rsp", 32'(rsp_valid_out), 'h0);
      stepCycle();
    end

    // Single requester, latency 2
    applyStimulus(4'b0100, 10'h0, 10'h0, 10'h3A1, 10'h0, 1'b0);
    @(negedge clk_in);
    checkOutput("t2_ready", 32'(req_ready_out), 'h4);
    checkOutput("t2_en", 32'(ram_en_out), 'h1);
    checkOutput("t2_addr", 32'(ram_addr_out), 'h3A1);
    checkOutput("t2_rsp0", 32'(rsp_valid_out), 'h0);
    stepCycle();
    applyStimulus(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 1'b0);
    @(negedge clk_in);
    checkOutput("t2_idle_ready", 32'(req_ready_out), 'h0);
    checkOutput("t2_idle_en", 32'(ram_en_out), 'h0);
    checkOutput("t2_rsp1", 32'(rsp_valid_out), 'h0);
    stepCycle();
    @(negedge clk_in);
    checkOutput("t2_rsp2", 32'(rsp_valid_out), 'h4);
    checkOutput("t2_data", 32'(rsp_data_out), 'h7C);
    stepCycle();

    // Pointer wrap from 3: grant 3, then 0, then the pointer sits at 1
    applyStimulus(4'b1001, 10'h011, 10'h0, 10'h0, 10'h233, 1'b0);
    @(negedge clk_in);
    checkOutput("t4_ready3", 32'(req_ready_out), 'h8);
    checkOutput("t4_addr3", 32'(ram_addr_out), 'h233);
    stepCycle();
    applyStimulus(4'b0001, 10'h011, 10'h0, 10'h0, 10'h0, 1'b0);
    @(negedge clk_in);
    checkOutput("t4_ready0", 32'(req_ready_out), 'h1);
    checkOutput("t4_addr0", 32'(ram_addr_out), 'h011);
    stepCycle();
    applyStimulus(4'b0011, 10'h044, 10'h155, 10'h0, 10'h0, 1'b0);
    @(negedge clk_in);
    checkOutput("t4_ptr1_ready", 32'(req_ready_out), 'h2);
    checkOutput("t4_ptr1_addr", 32'(ram_addr_out), 'h155);
    checkOutput("t4_rsp3", 32'(rsp_valid_out), 'h8);
    checkOutput("t4_data3", 32'(rsp_data_out), 'hEF);
    stepCycle();
    applyStimulus(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 1'b0);
    @(negedge clk_in);
    checkOutput("t4_rsp0", 32'(rsp_valid_out), 'h1);
    checkOutput("t4_data0", 32'(rsp_data_out), 'hCF);
    stepCycle();
    @(negedge clk_in);
    checkOutput("t4_rsp1", 32'(rsp_valid_out), 'h2);
    checkOutput("t4_data1", 32'(rsp_data_out), 'h8A);
    stepCycle();

    // Reset again so the rotation starts from 0
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("rst2_starve", 32'(starve_out), 'h0);
    stepCycle();
    rst_in = 1'b1;

    // All four requesters valid for 8 cycles
    for (int k = 0; k < 10; k++) begin
      if (k < 8) applyStimulus(4'b1111, 10'h000, 10'h100, 10'h200, 10'h300, 1'b0);
      else       applyStimulus(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 1'b0);
      @(negedge clk_in);
      if (k < 8) begin
        checkOutput($sformatf("t3_ready_%0d", k), 32'(req_ready_out), 32'(grant_seq[k]));
        checkOutput($sformatf("t3_addr_%0d", k), 32'(ram_addr_out), 32'((k % 4) * 256));
      end else begin
        checkOutput($sformatf("t3_ready_%0d", k), 32'(req_ready_out), 'h0);
      end
      if (k >= 2) begin
        checkOutput($sformatf("t3_rsp_%0d", k), 32'(rsp_valid_out), 32'(grant_seq[k-2]));
        checkOutput($sformatf("t3_data_%0d", k), 32'(rsp_data_out), 32'(data_seq[(k-2) % 4]));
      end else begin
        checkOutput($sformatf("t3_rsp_%0d", k), 32'(rsp_valid_out), 'h0);
      end
      checkOutput($sformatf("t3_starve_%0d", k), 32'(starve_out), 'h0);
      stepCycle();
    end

    // Requesters 0 and 1 valid for 20 cycles, then 1 alone, then a clear
    for (int k = 0; k < 23; k++) begin
      if (k < 20)       applyStimulus(4'b0011, 10'h0F0, 10'h10F, 10'h0, 10'h0, k == 16);
      else if (k == 20) applyStimulus(4'b0010, 10'h0, 10'h10F, 10'h0, 10'h0, 1'b0);
      else              applyStimulus(4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, k == 21);
      @(negedge clk_in);
`ifdef SPRITE_ARB_PRIO0_EN
      exp_ready  = (k < 20) ? 4'b0001 : (k == 20) ? 4'b0010 : 4'b0000;
      exp_starve = (k >= 15 && k <= 21) ? 4'b0010 : 4'b0000;
`else
      exp_ready  = (k < 20) ? ((k % 2 == 0) ? 4'b0001 : 4'b0010) : (k == 20) ? 4'b0010 : 4'b0000;
      exp_starve = 4'b0000;
`endif
      checkOutput($sformatf("t5_ready_%0d", k), 32'(req_ready_out), 32'(exp_ready));
      checkOutput($sformatf("t5_starve_%0d", k), 32'(starve_out), 32'(exp_starve));
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
